// File: rtl/config_loader_if.sv
// Host-side handshake bundle for config_loader: word load path, readback path and status.
interface config_loader_if #(
    parameter int WORD_W = 8
);
    logic              load_start;
    logic              rb_start;
    logic [WORD_W-1:0] in_dataA;
    logic [WORD_W-1:0] in_dataB;
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] out_dataA;
    logic [WORD_W-1:0] out_dataB;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              done;

    modport master (
        output load_start, rb_start, in_dataA, in_dataB, in_valid, out_ready,
        input  in_ready, out_dataA, out_dataB, out_valid, busy, done
    );

    modport slave (
        input  load_start, rb_start, in_dataA, in_dataB, in_valid, out_ready,
        output in_ready, out_dataA, out_dataB, out_valid, busy, done
    );
endinterface

// File: rtl/config_loader.sv
// Serialises host words MSB-first into the two CB config chains and reads them back
// non-destructively by recirculating each chain tail into its head.
module config_loader #(
    parameter int CHAIN_LEN = 25,
    parameter int WORD_W    = 8
) (
    input  logic            clk,
    input  logic            nrst,
    config_loader_if.slave  host,
    output logic            cfg_en,
    output logic            cfg_outA,
    output logic            cfg_outB,
    input  logic            cfg_retA,
    input  logic            cfg_retB
);
    localparam int NW  = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam int PAD = NW * WORD_W - CHAIN_LEN;
    localparam int WCW = $clog2(NW + 1);
    localparam int BCW = $clog2(WORD_W + 1);

    localparam logic [WCW-1:0] LAST_WORD = WCW'(NW);
    localparam logic [BCW-1:0] LAST_BIT  = BCW'(WORD_W - 1);
    localparam logic [BCW-1:0] PAD_BITS  = BCW'(PAD);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] LD_WAIT  = 3'd1;
    localparam logic [2:0] LD_SHIFT = 3'd2;
    localparam logic [2:0] RB_SHIFT = 3'd3;
    localparam logic [2:0] RB_OUT   = 3'd4;

    logic [2:0]        state;
    logic [WCW-1:0]    word_cnt;
    logic [BCW-1:0]    bit_cnt;
    logic [WORD_W-1:0] shA, shB;
    logic [WORD_W-1:0] rdA, rdB;
    logic              done_q;

    // cfg_en is a flop that is set on entry to either shift state and cleared on exit,
    // so it is high exactly while the chain is being shifted.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state    <= IDLE;
            word_cnt <= '0;
            bit_cnt  <= '0;
            shA      <= '0;
            shB      <= '0;
            rdA      <= '0;
            rdB      <= '0;
            cfg_en   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (host.load_start) begin
                        state    <= LD_WAIT;
                        word_cnt <= '0;
                    end else if (host.rb_start) begin
                        // The first readback word carries the pad bits as leading zeros.
                        state    <= RB_SHIFT;
                        word_cnt <= '0;
                        bit_cnt  <= PAD_BITS;
                        rdA      <= '0;
                        rdB      <= '0;
                        cfg_en   <= 1'b1;
                    end
                end
                LD_WAIT: begin
                    if (host.in_valid) begin
                        shA      <= host.in_dataA;
                        shB      <= host.in_dataB;
                        bit_cnt  <= '0;
                        word_cnt <= word_cnt + WCW'(1);
                        cfg_en   <= 1'b1;
                        state    <= LD_SHIFT;
                    end
                end
                LD_SHIFT: begin
                    shA     <= shA << 1;
                    shB     <= shB << 1;
                    bit_cnt <= bit_cnt + BCW'(1);
                    if (bit_cnt == LAST_BIT) begin
                        cfg_en <= 1'b0;
                        if (word_cnt == LAST_WORD) begin
                            done_q <= 1'b1;
                            state  <= IDLE;
                        end else begin
                            state  <= LD_WAIT;
                        end
                    end
                end
                RB_SHIFT: begin
                    rdA     <= {rdA[WORD_W-2:0], cfg_retA};
                    rdB     <= {rdB[WORD_W-2:0], cfg_retB};
                    bit_cnt <= bit_cnt + BCW'(1);
                    if (bit_cnt == LAST_BIT) begin
                        cfg_en   <= 1'b0;
                        word_cnt <= word_cnt + WCW'(1);
                        state    <= RB_OUT;
                    end
                end
                RB_OUT: begin
                    if (host.out_ready) begin
                        if (word_cnt == LAST_WORD) begin
                            done_q <= 1'b1;
                            state  <= IDLE;
                        end else begin
                            bit_cnt <= '0;
                            cfg_en  <= 1'b1;
                            state   <= RB_SHIFT;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // During readback the tail recirculates straight into the head so the chain is restored.
    always_comb begin
        cfg_outA = 1'b0;
        cfg_outB = 1'b0;
        case (state)
            LD_SHIFT: begin
                cfg_outA = shA[WORD_W-1];
                cfg_outB = shB[WORD_W-1];
            end
            RB_SHIFT: begin
                cfg_outA = cfg_retA;
                cfg_outB = cfg_retB;
            end
            default: ;
        endcase
    end

    assign host.in_ready  = (state == LD_WAIT);
    assign host.out_valid = (state == RB_OUT);
    assign host.out_dataA = (state == RB_OUT) ? rdA : '0;
    assign host.out_dataB = (state == RB_OUT) ? rdB : '0;
    assign host.busy      = (state != IDLE);
    assign host.done      = done_q;
endmodule

// File: tb/tb_config_loader.sv
// Bench for config_loader: emulates the two CB shift chains and checks loads and readbacks
// of random chain images against expected words derived from the chain contents.
module tb_config_loader;
    localparam int CHAIN_LEN = 25;
    localparam int WORD_W    = 8;
    localparam int NW        = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam int STREAM_W  = NW * WORD_W;

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    config_loader_if #(.WORD_W(WORD_W)) host();
    logic cfg_en, cfg_outA, cfg_outB, cfg_retA, cfg_retB;

    config_loader #(.CHAIN_LEN(CHAIN_LEN), .WORD_W(WORD_W)) dut (
        .clk      (clk),
        .nrst     (nrst),
        .host     (host.slave),
        .cfg_en   (cfg_en),
        .cfg_outA (cfg_outA),
        .cfg_outB (cfg_outB),
        .cfg_retA (cfg_retA),
        .cfg_retB (cfg_retB)
    );

    // Stand-in for the CB chains: shift on every enabled edge, tail feeds back to the loader.
    logic [CHAIN_LEN-1:0] chainA, chainB;
    always @(posedge clk) begin
        if (cfg_en) begin
            chainA <= {chainA[CHAIN_LEN-2:0], cfg_outA};
            chainB <= {chainB[CHAIN_LEN-2:0], cfg_outB};
        end
    end
    assign cfg_retA = chainA[CHAIN_LEN-1];
    assign cfg_retB = chainB[CHAIN_LEN-1];

    int total = 0;
    int bad   = 0;
    int en_cnt, done_cnt, hs_err, ov_err;
    bit in_rb = 1'b0;

    initial begin
        en_cnt = 0; done_cnt = 0; hs_err = 0; ov_err = 0;
    end

    always @(negedge clk) begin
        if (cfg_en) en_cnt++;
        if (host.done) done_cnt++;
        if (host.in_ready && cfg_en) hs_err++;
        if (host.out_valid && !in_rb) ov_err++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    // Word k of the zero-padded stream image of a chain value, most significant word first.
    function automatic logic [WORD_W-1:0] word_of(input logic [CHAIN_LEN-1:0] v, input int k);
        logic [STREAM_W-1:0] s;
        s = STREAM_W'(v);
        return WORD_W'(s >> ((NW - 1 - k) * WORD_W));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string tag);
        int budget = 0;
        while (!host.done && budget < 60) begin
            tick();
            budget++;
        end
        if (budget >= 60) checkOutput(tag, 32'd0, 32'd1);
    endtask

    task automatic applyStimulus(input logic [CHAIN_LEN-1:0] a, input logic [CHAIN_LEN-1:0] b,
                                 input int min_gap, input int max_gap,
                                 input bit both_starts, input bit rb_busy);
        int budget;
        en_cnt = 0; done_cnt = 0; hs_err = 0;
        host.load_start = 1'b1;
        host.rb_start   = both_starts;
        tick();
        host.load_start = 1'b0;
        host.rb_start   = 1'b0;
        if (both_starts) checkOutput("both_start_takes_load", 32'(host.in_ready), 32'd1);
        for (int k = 0; k < NW; k++) begin
            repeat ($urandom_range(max_gap, min_gap)) tick();
            host.in_dataA = word_of(a, k);
            host.in_dataB = word_of(b, k);
            host.in_valid = 1'b1;
            budget = 0;
            while (!host.in_ready && budget < 50) begin
                tick();
                budget++;
            end
            if (budget >= 50) checkOutput("in_ready_timeout", 32'd0, 32'd1);
            tick();
            host.in_valid = 1'b0;
            host.in_dataA = WORD_W'($urandom);
            host.in_dataB = WORD_W'($urandom);
            if (rb_busy && k == 1) begin
                host.rb_start = 1'b1;
                tick();
                host.rb_start = 1'b0;
            end
        end
        wait_done("load_done_timeout");
        repeat (3) tick();
        checkOutput("load_en_cycles", 32'(en_cnt), 32'(STREAM_W));
        checkOutput("load_done_count", 32'(done_cnt), 32'd1);
        checkOutput("load_chainA", 32'(chainA), 32'(a));
        checkOutput("load_chainB", 32'(chainB), 32'(b));
        checkOutput("load_idle_busy", 32'(host.busy), 32'd0);
        checkOutput("load_stall_no_shift", 32'(hs_err), 32'd0);
    endtask

    task automatic readback(input logic [CHAIN_LEN-1:0] a, input logic [CHAIN_LEN-1:0] b,
                            input int min_stall, input int max_stall);
        int budget;
        int stall_err;
        logic [WORD_W-1:0] held_a, held_b;
        in_rb = 1'b1;
        en_cnt = 0; done_cnt = 0;
        host.rb_start = 1'b1;
        tick();
        host.rb_start = 1'b0;
        for (int k = 0; k < NW; k++) begin
            budget = 0;
            while (!host.out_valid && budget < 50) begin
                tick();
                budget++;
            end
            if (budget >= 50) checkOutput("out_valid_timeout", 32'd0, 32'd1);
            held_a = host.out_dataA;
            held_b = host.out_dataB;
            stall_err = 0;
            repeat ($urandom_range(max_stall, min_stall)) begin
                tick();
                if (host.out_dataA !== held_a || host.out_dataB !== held_b || cfg_en || !host.out_valid)
                    stall_err++;
            end
            checkOutput($sformatf("rb_word%0d_A", k), 32'(host.out_dataA), 32'(word_of(a, k)));
            checkOutput($sformatf("rb_word%0d_B", k), 32'(host.out_dataB), 32'(word_of(b, k)));
            checkOutput($sformatf("rb_word%0d_stall", k), 32'(stall_err), 32'd0);
            host.out_ready = 1'b1;
            tick();
            host.out_ready = 1'b0;
        end
        wait_done("rb_done_timeout");
        repeat (3) tick();
        in_rb = 1'b0;
        checkOutput("rb_en_cycles", 32'(en_cnt), 32'(CHAIN_LEN));
        checkOutput("rb_done_count", 32'(done_cnt), 32'd1);
        checkOutput("rb_chainA_restored", 32'(chainA), 32'(a));
        checkOutput("rb_chainB_restored", 32'(chainB), 32'(b));
    endtask

    function automatic logic [31:0] out_vector();
        return 32'({host.in_ready, host.out_valid, host.busy, host.done, cfg_en, cfg_outA, cfg_outB,
                    host.out_dataA, host.out_dataB});
    endfunction

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [CHAIN_LEN-1:0] a, b;
        host.load_start = 1'b0;
        host.rb_start   = 1'b0;
        host.in_dataA   = '0;
        host.in_dataB   = '0;
        host.in_valid   = 1'b0;
        host.out_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_outputs", out_vector(), 32'd0);
        @(negedge clk);
        nrst = 1'b1;
        tick();
        checkOutput("post_reset_outputs", out_vector(), 32'd0);

        applyStimulus(25'h0ABCDEF, 25'h1234567, 0, 0, 1'b0, 1'b0);
        readback(25'h0ABCDEF, 25'h1234567, 0, 0);
        readback(25'h0ABCDEF, 25'h1234567, 0, 0);
        readback(25'h0ABCDEF, 25'h1234567, 10, 10);
        applyStimulus(25'h1FFFFFF, 25'h0000000, 5, 5, 1'b0, 1'b0);
        readback(25'h1FFFFFF, 25'h0000000, 0, 2);

        for (int i = 0; i < 6; i++) begin
            a = CHAIN_LEN'($urandom);
            b = CHAIN_LEN'($urandom);
            applyStimulus(a, b, 0, 4, 1'b0, 1'b0);
            readback(a, b, 0, 3);
        end

        a = CHAIN_LEN'($urandom);
        b = CHAIN_LEN'($urandom);
        applyStimulus(a, b, 0, 2, 1'b1, 1'b1);
        checkOutput("rb_while_busy_ignored", 32'(host.out_valid), 32'd0);
        readback(a, b, 0, 1);

        // Abort a load partway through the first word's shift.
        done_cnt = 0;
        host.load_start = 1'b1;
        tick();
        host.load_start = 1'b0;
        host.in_dataA = 8'hA5;
        host.in_dataB = 8'h5A;
        host.in_valid = 1'b1;
        tick();
        host.in_valid = 1'b0;
        tick();
        tick();
        checkOutput("abort_was_shifting", 32'(cfg_en), 32'd1);
        nrst = 1'b0;
        #1;
        checkOutput("abort_outputs", out_vector(), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        nrst = 1'b1;
        repeat (3) tick();
        checkOutput("abort_no_done", 32'(done_cnt), 32'd0);
        checkOutput("abort_idle", 32'(host.busy), 32'd0);

        a = CHAIN_LEN'($urandom);
        b = CHAIN_LEN'($urandom);
        applyStimulus(a, b, 0, 3, 1'b0, 1'b0);
        readback(a, b, 0, 3);

        checkOutput("out_valid_outside_rb", 32'(ov_err), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
